// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: channel opcodes, burst beat count, responder FSM states.
package tl_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITHMETIC  = 3'd2;
    localparam logic [2:0] A_LOGICAL     = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ACK,
        ST_READ
    } tl_state_e;

    // Sizes above one 64-bit word become bursts; out-of-range sizes collapse to one beat.
    function automatic logic [3:0] beat_count(input logic [3:0] size);
        if (size >= 4'd4 && size <= 4'd6) begin
            return 4'd1 << (size - 4'd3);
        end
        return 4'd1;
    endfunction

    function automatic logic carries_data(input logic [2:0] opcode);
        return opcode <= A_LOGICAL;
    endfunction

endpackage

// File: rtl/tl_slave_mem_array.sv
// 64-bit word storage with per-byte write enables and a combinational read port; never reset.
module tl_slave_mem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [7:0]            be,
    input  logic [DEPTH_LOG2-1:0] widx,
    input  logic [63:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] ridx,
    output logic [63:0]           rdata
);

    logic [63:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/tl_slave_mem.sv
// TileLink-UL memory responder: Get/Put, single-beat or burst, one outstanding transaction.
module tl_slave_mem
    import tl_pkg::*;
#(
    parameter int                    SRC_SIZE   = 2,
    parameter int                    SINK_SIZE  = 2,
    parameter int                    BUS_SIZE   = 8,
    parameter int                    ADR_WIDTH  = 32,
    parameter logic [ADR_WIDTH-1:0]  BASE_ADDR  = 32'h6000_0000,
    parameter int                    DEPTH_LOG2 = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    tl_slave_a_ready,
    input  logic                    tl_slave_a_valid,
    input  logic [2:0]              tl_slave_a_bits_opcode,
    input  logic [2:0]              tl_slave_a_bits_param,
    input  logic [3:0]              tl_slave_a_bits_size,
    input  logic [SRC_SIZE-1:0]     tl_slave_a_bits_source,
    input  logic [ADR_WIDTH-1:0]    tl_slave_a_bits_address,
    input  logic [BUS_SIZE-1:0]     tl_slave_a_bits_mask,
    input  logic [8*BUS_SIZE-1:0]   tl_slave_a_bits_data,
    input  logic                    tl_slave_a_bits_corrupt,
    input  logic                    tl_slave_d_ready,
    output logic                    tl_slave_d_valid,
    output logic [2:0]              tl_slave_d_bits_opcode,
    output logic [1:0]              tl_slave_d_bits_param,
    output logic [3:0]              tl_slave_d_bits_size,
    output logic [SRC_SIZE-1:0]     tl_slave_d_bits_source,
    output logic [SINK_SIZE-1:0]    tl_slave_d_bits_sink,
    output logic                    tl_slave_d_bits_denied,
    output logic [8*BUS_SIZE-1:0]   tl_slave_d_bits_data,
    output logic                    tl_slave_d_bits_corrupt
);

    localparam logic [ADR_WIDTH-1:0] MEM_BYTES = ADR_WIDTH'(64'd8 << DEPTH_LOG2);

    tl_state_e             state_q, state_d;
    logic                  a_ready_q, a_ready_d;
    logic                  d_valid_q, d_valid_d;
    logic [2:0]            d_opcode_q, d_opcode_d;
    logic [3:0]            d_size_q, d_size_d;
    logic [SRC_SIZE-1:0]   d_source_q, d_source_d;
    logic                  d_denied_q, d_denied_d;
    logic                  d_corrupt_q, d_corrupt_d;
    logic [2:0]            beat_q, beat_d;
    logic [2:0]            last_q, last_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;

    logic                  a_fire;
    logic [ADR_WIDTH-1:0]  a_offset;
    logic                  a_in_range;
    logic                  a_aligned;
    logic                  a_supported;
    logic                  a_denied;
    logic [3:0]            a_beats;
    logic [2:0]            a_last;
    logic [DEPTH_LOG2-1:0] a_index;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [63:0]           rd_data;
    logic                  unused_ok;

    // Decode of the request currently presented on A.
    always_comb begin
        a_fire      = tl_slave_a_valid & a_ready_q;
        a_offset    = tl_slave_a_bits_address - BASE_ADDR;
        a_in_range  = (tl_slave_a_bits_address >= BASE_ADDR) && (a_offset < MEM_BYTES);
        a_aligned   = (tl_slave_a_bits_address & ~({ADR_WIDTH{1'b1}} << tl_slave_a_bits_size)) == '0;
        a_supported = (tl_slave_a_bits_opcode == A_PUT_FULL) ||
                      (tl_slave_a_bits_opcode == A_PUT_PARTIAL) ||
                      (tl_slave_a_bits_opcode == A_GET);
        a_denied    = !a_in_range || !a_aligned || (tl_slave_a_bits_size > 4'd6) || !a_supported;
        a_beats     = beat_count(tl_slave_a_bits_size);
        a_last      = 3'(a_beats - 4'd1);
        a_index     = a_offset[DEPTH_LOG2+2:3];
        cur_idx     = base_q + DEPTH_LOG2'(beat_q);
    end

    always_comb begin
        state_d     = state_q;
        a_ready_d   = a_ready_q;
        d_valid_d   = d_valid_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_denied_d  = d_denied_q;
        d_corrupt_d = d_corrupt_q;
        beat_d      = beat_q;
        last_d      = last_q;
        base_d      = base_q;
        mem_we      = 1'b0;
        mem_widx    = cur_idx;

        case (state_q)
            ST_IDLE: begin
                a_ready_d = 1'b1;
                if (a_fire) begin
                    d_opcode_d  = (tl_slave_a_bits_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                    d_size_d    = tl_slave_a_bits_size;
                    d_source_d  = tl_slave_a_bits_source;
                    d_denied_d  = a_denied;
                    d_corrupt_d = a_denied && (tl_slave_a_bits_opcode == A_GET);
                    base_d      = a_index;
                    last_d      = a_last;
                    beat_d      = 3'd0;
                    mem_widx    = a_index;
                    mem_we      = !a_denied && carries_data(tl_slave_a_bits_opcode) &&
                                  !tl_slave_a_bits_corrupt;
                    if (carries_data(tl_slave_a_bits_opcode) && a_last != 3'd0) begin
                        state_d = ST_WRITE;
                        beat_d  = 3'd1;
                    end else begin
                        state_d   = (tl_slave_a_bits_opcode == A_GET) ? ST_READ : ST_ACK;
                        a_ready_d = 1'b0;
                        d_valid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (a_fire) begin
                    mem_we = !d_denied_q && !tl_slave_a_bits_corrupt;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == last_q) begin
                        state_d   = ST_ACK;
                        a_ready_d = 1'b0;
                        d_valid_d = 1'b1;
                        beat_d    = 3'd0;
                    end
                end
            end
            ST_ACK: begin
                if (tl_slave_d_ready) begin
                    state_d   = ST_IDLE;
                    d_valid_d = 1'b0;
                    a_ready_d = 1'b1;
                end
            end
            ST_READ: begin
                if (tl_slave_d_ready) begin
                    if (beat_q == last_q) begin
                        state_d   = ST_IDLE;
                        d_valid_d = 1'b0;
                        a_ready_d = 1'b1;
                        beat_d    = 3'd0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_ready_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            beat_q      <= '0;
            last_q      <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            a_ready_q   <= a_ready_d;
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_denied_q  <= d_denied_d;
            d_corrupt_q <= d_corrupt_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            base_q      <= base_d;
        end
    end

    tl_slave_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .be    (tl_slave_a_bits_mask),
        .widx  (mem_widx),
        .wdata (tl_slave_a_bits_data),
        .ridx  (cur_idx),
        .rdata (rd_data)
    );

    assign unused_ok = ^tl_slave_a_bits_param;

    assign tl_slave_a_ready        = a_ready_q;
    assign tl_slave_d_valid        = d_valid_q;
    assign tl_slave_d_bits_opcode  = d_opcode_q;
    assign tl_slave_d_bits_param   = 2'd0;
    assign tl_slave_d_bits_size    = d_size_q;
    assign tl_slave_d_bits_source  = d_source_q;
    assign tl_slave_d_bits_sink    = '0;
    assign tl_slave_d_bits_denied  = d_denied_q;
    assign tl_slave_d_bits_corrupt = d_corrupt_q;
    // Data is only ever driven for an allowed Get; acks and denied reads return zero.
    assign tl_slave_d_bits_data    = (state_q == ST_READ && !d_denied_q) ? rd_data : '0;

endmodule
